piso_tx: RTL and testbench

- Parallel-in serial-out transmitter; the transmit end of the serial link whose receive end is the existing `sipo` block.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per `clk` on `dout`, qualified by `dout_valid`.
- Supports back-to-back words with no idle gap, so a downstream `sipo` sees a continuous bit stream.

---
 rtl/serial_link_pkg.sv | 16 +
 rtl/piso_tx.sv | 84 ++++++++
 tb/tb_piso_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link (piso_tx transmit end, sipo receive end).
// frame_len() gives the bits per frame, including the optional parity bit.
package serial_link_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clk on dout.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             done
);

`ifdef PISO_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int unsigned FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    state_t               state;
    logic [FRAME_LEN-1:0] sreg;
    logic [FRAME_LEN-1:0] frame;
    logic [FRAME_LEN-1:0] sreg_next;
    logic [CNT_W-1:0]     cnt;
    logic                 frame_head;
    logic                 next_head;
    logic                 accept;

    // cnt is zero throughout IDLE, so this is ready in IDLE or on the final frame bit.
    assign load_ready = (state == IDLE) || (cnt == '0);
    assign accept     = load_valid && load_ready;

    // The shift register always holds the bit currently on dout at its outgoing end.
    always_comb begin
`ifdef PISO_TX_PARITY_EN
        frame = (MSB_FIRST != 0) ? {din, ^din} : {^din, din};
`else
        frame = din;
`endif
        sreg_next  = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
        frame_head = (MSB_FIRST != 0) ? frame[FRAME_LEN-1] : frame[0];
        next_head  = (MSB_FIRST != 0) ? sreg_next[FRAME_LEN-1] : sreg_next[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            sreg       <= frame;
            cnt        <= CNT_W'(FRAME_LEN - 1);
            dout       <= frame_head;
            dout_valid <= 1'b1;
            done       <= (FRAME_LEN == 1);
        end else if (state == SHIFT && cnt != '0) begin
            sreg       <= sreg_next;
            cnt        <= cnt - 1'b1;
            dout       <= next_head;
            dout_valid <= 1'b1;
            done       <= (cnt == CNT_W'(1));
        end else begin
            // Idle, or final bit sent with no follow-on word.
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=4, MSB_FIRST=1).
// The parity scenario is built only when PISO_TX_PARITY_EN is defined.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       load_valid;
    logic       load_ready;
    logic       dout;
    logic       dout_valid;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    piso_tx #(
        .WIDTH     (4),
        .MSB_FIRST (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        load_valid = 1'b1;
        din        = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (load_ready !== 1'b1 || dout !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL reset cyc%0d: ready=%b dout=%b valid=%b done=%b, want 1 0 0 0",
                         i, load_ready, dout, dout_valid, done);
            end
        end
        rst        = 1'b1;
        load_valid = 1'b0;
        tick();
        n_cmp++;
        if (dout_valid !== 1'b0 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: valid=%b ready=%b, want valid=0 ready=1",
                     dout_valid, load_ready);
        end
    endtask

    task automatic test_single();
        logic [3:0] w;
        w          = 4'b1010;
        din        = w;
        load_valid = 1'b1;
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready_idle: ready=%b, want 1", load_ready);
        end
        tick();
        load_valid = 1'b0;
        din        = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dout !== w[3-i] || dout_valid !== 1'b1 || done !== 1'(i == 3)
                || load_ready !== 1'(i == 3)) begin
                n_err++;
                $display("FAIL single bit%0d: dout=%b valid=%b done=%b ready=%b, want %b 1 %b %b",
                         i, dout, dout_valid, done, load_ready, w[3-i], i == 3, i == 3);
            end
            tick();
        end
        n_cmp++;
        if (dout !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_idle: dout=%b valid=%b done=%b ready=%b, want 0 0 0 1",
                     dout, dout_valid, done, load_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        exp        = 8'b1100_0011;
        din        = 4'b1100;
        load_valid = 1'b1;
        tick();
        din = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) load_valid = 1'b0;
            n_cmp++;
            if (dout !== exp[7-i] || dout_valid !== 1'b1 || done !== 1'(i == 3 || i == 7)
                || load_ready !== 1'(i == 3 || i == 7)) begin
                n_err++;
                $display("FAIL b2b bit%0d: dout=%b valid=%b done=%b ready=%b, want %b 1 %b %b",
                         i, dout, dout_valid, done, load_ready, exp[7-i],
                         i == 3 || i == 7, i == 3 || i == 7);
            end
            tick();
        end
        n_cmp++;
        if (dout_valid !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: valid=%b done=%b, want 0 0", dout_valid, done);
        end
    endtask

    task automatic test_ignored_load();
        logic [7:0] exp;
        exp        = 8'b1010_1111;
        din        = 4'b1010;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                load_valid = 1'b1;
                din        = 4'b1111;
            end
            if (i == 4) load_valid = 1'b0;
            n_cmp++;
            if (dout !== exp[7-i] || dout_valid !== 1'b1 || done !== 1'(i == 3 || i == 7)) begin
                n_err++;
                $display("FAIL ignored bit%0d: dout=%b valid=%b done=%b, want %b 1 %b",
                         i, dout, dout_valid, done, exp[7-i], i == 3 || i == 7);
            end
            tick();
        end
        n_cmp++;
        if (dout_valid !== 1'b0 || load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_idle: valid=%b ready=%b, want 0 1", dout_valid, load_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] w;
        din        = 4'b0110;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if (dout !== 1'b0 || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst bit0: dout=%b valid=%b, want 0 1", dout, dout_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (dout !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
                n_err++;
                $display("FAIL midrst cyc%0d: dout=%b valid=%b done=%b ready=%b, want 0 0 0 1",
                         i, dout, dout_valid, done, load_ready);
            end
            if (i == 0) rst = 1'b1;
            tick();
        end
        w          = 4'b0101;
        din        = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dout !== w[3-i] || dout_valid !== 1'b1 || done !== 1'(i == 3)) begin
                n_err++;
                $display("FAIL postrst bit%0d: dout=%b valid=%b done=%b, want %b 1 %b",
                         i, dout, dout_valid, done, w[3-i], i == 3);
            end
            tick();
        end
    endtask

`ifdef PISO_TX_PARITY_EN
    task automatic test_parity();
        logic [4:0] exp;
        logic [3:0] rx;
        exp        = 5'b1011_1;
        rx         = 4'b0000;
        din        = 4'b1011;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rx = {rx[2:0], dout};
            n_cmp++;
            if (dout !== exp[4-i] || dout_valid !== 1'b1 || done !== 1'(i == 4)) begin
                n_err++;
                $display("FAIL parity bit%0d: dout=%b valid=%b done=%b, want %b 1 %b",
                         i, dout, dout_valid, done, exp[4-i], i == 4);
            end
            tick();
        end
        n_cmp++;
        if (rx !== 4'b1011) begin
            n_err++;
            $display("FAIL parity_loopback: got %b, want 1011", rx);
        end
    endtask
`endif

    initial begin
        rst        = 1'b0;
        din        = 4'b0000;
        load_valid = 1'b0;
        test_reset();
`ifdef PISO_TX_PARITY_EN
        test_parity();
`else
        test_single();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid_frame();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
